// File: rtl/datapath_pkg.sv
// Shared encodings for the pipelined datapath: ALU function codes, writeback
// source selects and the execute-stage state type.
package datapath_pkg;

  localparam logic [3:0] FS_PASS_A = 4'h0;
  localparam logic [3:0] FS_INC    = 4'h1;
  localparam logic [3:0] FS_ADD    = 4'h2;
  localparam logic [3:0] FS_SUB    = 4'h3;
  localparam logic [3:0] FS_AND    = 4'h4;
  localparam logic [3:0] FS_OR     = 4'h5;
  localparam logic [3:0] FS_XOR    = 4'h6;
  localparam logic [3:0] FS_NOT    = 4'h7;
  localparam logic [3:0] FS_SHL    = 4'h8;
  localparam logic [3:0] FS_SHR    = 4'h9;

  localparam logic [1:0] MB_ALU  = 2'd0;
  localparam logic [1:0] MB_IMM  = 2'd1;
  localparam logic [1:0] MB_PC   = 2'd2;
  localparam logic [1:0] MB_ZERO = 2'd3;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_RUN  = 2'd1,
    EX_LOAD = 2'd2
  } ex_state_t;

endpackage

// File: rtl/alu_param.sv
// Combinational WIDTH-bit ALU with V/C/N/Z. C is carry out for INC/ADD, borrow
// for SUB (set when A < B unsigned) and the shifted-out bit for SHL/SHR.
module alu_param
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       FS,
  output logic [WIDTH-1:0] F,
  output logic             V,
  output logic             C,
  output logic             N,
  output logic             Z
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum = '0;
    F     = A;
    V     = 1'b0;
    C     = 1'b0;
    case (FS)
      FS_PASS_A: F = A;
      FS_INC: begin
        w_sum = {1'b0, A} + (WIDTH+1)'(1);
        F     = w_sum[WIDTH-1:0];
        C     = w_sum[WIDTH];
        V     = !A[WIDTH-1] && F[WIDTH-1];
      end
      FS_ADD: begin
        w_sum = {1'b0, A} + {1'b0, B};
        F     = w_sum[WIDTH-1:0];
        C     = w_sum[WIDTH];
        V     = (A[WIDTH-1] == B[WIDTH-1]) && (F[WIDTH-1] != A[WIDTH-1]);
      end
      FS_SUB: begin
        w_sum = {1'b0, A} - {1'b0, B};
        F     = w_sum[WIDTH-1:0];
        C     = w_sum[WIDTH];
        V     = (A[WIDTH-1] != B[WIDTH-1]) && (F[WIDTH-1] != A[WIDTH-1]);
      end
      FS_AND: F = A & B;
      FS_OR:  F = A | B;
      FS_XOR: F = A ^ B;
      FS_NOT: F = ~A;
      FS_SHL: begin
        F = {A[WIDTH-2:0], 1'b0};
        C = A[WIDTH-1];
      end
      FS_SHR: begin
        F = {1'b0, A[WIDTH-1:1]};
        C = A[0];
      end
      default: F = A;
    endcase
    N = F[WIDTH-1];
    Z = (F == '0);
  end

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage datapath: operand select/issue into EX registers, then execute and
// writeback with forwarding into the issuing operands. Loads hold issue one cycle.
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int REGS  = 16,
  parameter int PC_W  = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     RW,
  input  logic                     MD,
  input  logic                     ASEL,
  input  logic [1:0]               MB,
  input  logic [3:0]               FS,
  input  logic [$clog2(REGS)-1:0]  SA,
  input  logic [$clog2(REGS)-1:0]  DR,
  input  logic [$clog2(REGS)-1:0]  BA,
  input  logic [PC_W-1:0]          PC,
  input  logic [WIDTH-1:0]         imdt,
  input  logic [WIDTH-1:0]         RAM_data_out,
  output logic [WIDTH-1:0]         A_out,
  output logic [WIDTH-1:0]         B_out,
  output logic                     out_valid,
  output logic                     V,
  output logic                     C,
  output logic                     N,
  output logic                     Z
);

  localparam int AW = $clog2(REGS);

  logic [WIDTH-1:0] r_regs [REGS];
  ex_state_t        r_state, w_state_nxt;

  logic [WIDTH-1:0] r_a_p1, r_b_p1, r_imdt_p1;
  logic [AW-1:0]    r_dr_p1;
  logic             r_rw_p1, r_md_p1;
  logic [1:0]       r_mb_p1;
  logic [3:0]       r_fs_p1;
  logic [PC_W-1:0]  r_pc_p1;
  logic             r_v, r_c, r_n, r_z;

  logic             w_accept, w_retire, w_we, w_flag_we;
  logic [AW-1:0]    w_a_addr;
  logic [WIDTH-1:0] w_a_fwd, w_b_fwd, w_wb_data, w_f;
  logic             w_v, w_c, w_n, w_z;

  // Issue stage: operand select with forwarding from the retiring instruction
  assign in_ready = !((r_state == EX_RUN) && r_md_p1);
  assign w_accept = in_valid && in_ready;
  assign w_a_addr = ASEL ? DR : SA;
  assign w_we     = w_retire && r_rw_p1;
  assign w_a_fwd  = (w_we && (r_dr_p1 == w_a_addr)) ? w_wb_data : r_regs[w_a_addr];
  assign w_b_fwd  = (w_we && (r_dr_p1 == BA))       ? w_wb_data : r_regs[BA];

  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    case (r_state)
      EX_IDLE: if (w_accept) w_state_nxt = EX_RUN;
      EX_RUN: begin
        if (r_md_p1) begin
          w_state_nxt = EX_LOAD;
        end else begin
          w_retire    = 1'b1;
          w_state_nxt = w_accept ? EX_RUN : EX_IDLE;
        end
      end
      EX_LOAD: begin
        w_retire    = 1'b1;
        w_state_nxt = w_accept ? EX_RUN : EX_IDLE;
      end
      default: w_state_nxt = EX_IDLE;
    endcase
  end

  // Execute/writeback stage
  alu_param #(.WIDTH(WIDTH)) u_alu (
    .A  (r_a_p1),
    .B  (r_b_p1),
    .FS (r_fs_p1),
    .F  (w_f),
    .V  (w_v),
    .C  (w_c),
    .N  (w_n),
    .Z  (w_z)
  );

  always_comb begin
    w_wb_data = '0;
    case (r_mb_p1)
      MB_ALU:  w_wb_data = r_md_p1 ? RAM_data_out : w_f;
      MB_IMM:  w_wb_data = r_imdt_p1;
      MB_PC:   w_wb_data = WIDTH'(r_pc_p1);
      default: w_wb_data = '0;
    endcase
  end

  assign w_flag_we = w_retire && !r_md_p1 && (r_mb_p1 == MB_ALU);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= EX_IDLE;
      r_a_p1    <= '0;
      r_b_p1    <= '0;
      r_imdt_p1 <= '0;
      r_dr_p1   <= '0;
      r_rw_p1   <= 1'b0;
      r_md_p1   <= 1'b0;
      r_mb_p1   <= '0;
      r_fs_p1   <= '0;
      r_pc_p1   <= '0;
      r_v       <= 1'b0;
      r_c       <= 1'b0;
      r_n       <= 1'b0;
      r_z       <= 1'b0;
      for (int i = 0; i < REGS; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a_p1    <= w_a_fwd;
        r_b_p1    <= w_b_fwd;
        r_imdt_p1 <= imdt;
        r_dr_p1   <= DR;
        r_rw_p1   <= RW;
        r_md_p1   <= MD;
        r_mb_p1   <= MB;
        r_fs_p1   <= FS;
        r_pc_p1   <= PC;
      end
      if (w_we) r_regs[r_dr_p1] <= w_wb_data;
      if (w_flag_we) begin
        r_v <= w_v;
        r_c <= w_c;
        r_n <= w_n;
        r_z <= w_z;
      end
    end
  end

  assign A_out     = r_a_p1;
  assign B_out     = r_b_p1;
  assign out_valid = w_retire;
  assign V         = r_v;
  assign C         = r_c;
  assign N         = r_n;
  assign Z         = r_z;

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe: a 16-bit instance for the main scenarios and
// an 8-bit/8-register instance for the narrow-width subtraction case.
module tb_datapath_pipe;
  import datapath_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        in_valid, in_ready, RW, MD, ASEL, out_valid, V, C, N, Z;
  logic [1:0]  MB;
  logic [3:0]  FS, SA, DR, BA;
  logic [5:0]  PC;
  logic [15:0] imdt, RAM_data_out, A_out, B_out;

  logic        in_valid8, in_ready8, RW8, MD8, ASEL8, out_valid8, V8, C8, N8, Z8;
  logic [1:0]  MB8;
  logic [3:0]  FS8;
  logic [2:0]  SA8, DR8, BA8;
  logic [5:0]  PC8;
  logic [7:0]  imdt8, RAM8, A_out8, B_out8;

  always #5 clk = ~clk;

  datapath_pipe #(.WIDTH(16), .REGS(16), .PC_W(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .RW(RW), .MD(MD), .ASEL(ASEL), .MB(MB), .FS(FS), .SA(SA), .DR(DR), .BA(BA),
    .PC(PC), .imdt(imdt), .RAM_data_out(RAM_data_out), .A_out(A_out), .B_out(B_out),
    .out_valid(out_valid), .V(V), .C(C), .N(N), .Z(Z)
  );

  datapath_pipe #(.WIDTH(8), .REGS(8), .PC_W(6)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .RW(RW8), .MD(MD8), .ASEL(ASEL8), .MB(MB8), .FS(FS8), .SA(SA8), .DR(DR8), .BA(BA8),
    .PC(PC8), .imdt(imdt8), .RAM_data_out(RAM8), .A_out(A_out8), .B_out(B_out8),
    .out_valid(out_valid8), .V(V8), .C(C8), .N(N8), .Z(Z8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic md, input logic asel,
                       input logic [1:0] mb, input logic [3:0] fs,
                       input logic [3:0] sa, input logic [3:0] dr, input logic [3:0] ba,
                       input logic [5:0] pc, input logic [15:0] im);
    in_valid = 1'b1; RW = rw; MD = md; ASEL = asel; MB = mb; FS = fs;
    SA = sa; DR = dr; BA = ba; PC = pc; imdt = im;
  endtask

  task automatic read_reg(input logic [3:0] r, output logic [15:0] v);
    drive(1'b0, 1'b0, 1'b0, MB_ZERO, FS_PASS_A, r, r, r, 6'd0, 16'd0);
    tick();
    v = A_out;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic write_imm(input logic [3:0] r, input logic [15:0] val);
    drive(1'b1, 1'b0, 1'b0, MB_IMM, FS_PASS_A, 4'd0, r, 4'd0, 6'd0, val);
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [15:0] v;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if ({A_out, B_out} !== 32'd0) begin errors++; $display("FAIL reset_operands got %h want 0", {A_out, B_out}); end
    checks++; if ({V, C, N, Z} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {V, C, N, Z}); end
    tick();
    reset = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    read_reg(4'd9, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_reg9 got %h want 0000", v); end
  endtask

  task automatic test_imm_pass();
    logic [15:0] v;
    drive(1'b1, 1'b0, 1'b0, MB_IMM, FS_PASS_A, 4'd0, 4'd3, 4'd0, 6'd0, 16'h1234);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL imm_idle_out_valid got %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL imm_retire_out_valid got %b want 1", out_valid); end
    drive(1'b1, 1'b0, 1'b0, MB_ALU, FS_PASS_A, 4'd3, 4'd4, 4'd0, 6'd0, 16'd0);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pass_retire_out_valid got %b want 1", out_valid); end
    checks++; if (A_out !== 16'h1234) begin errors++; $display("FAIL pass_fwd_A got %h want 1234", A_out); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_drain_out_valid got %b want 0", out_valid); end
    checks++; if ({N, Z} !== 2'b00) begin errors++; $display("FAIL pass_flags_NZ got %b want 00", {N, Z}); end
    read_reg(4'd4, v);
    checks++; if (v !== 16'h1234) begin errors++; $display("FAIL pass_reg4 got %h want 1234", v); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    write_imm(4'd1, 16'h7FFF);
    write_imm(4'd2, 16'h0001);
    drive(1'b1, 1'b0, 1'b0, MB_ALU, FS_ADD, 4'd1, 4'd5, 4'd2, 6'd0, 16'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, MB_ALU, FS_ADD, 4'd5, 4'd6, 4'd5, 6'd0, 16'd0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
    tick();
    checks++; if ({A_out, B_out} !== 32'h8000_8000) begin errors++; $display("FAIL b2b_fwd_AB got %h want 80008000", {A_out, B_out}); end
    checks++; if ({V, C, N, Z} !== 4'b1010) begin errors++; $display("FAIL add1_flags_VCNZ got %b want 1010", {V, C, N, Z}); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid got %b want 1", out_valid); end
    in_valid = 1'b0;
    tick();
    checks++; if ({V, C, N, Z} !== 4'b1101) begin errors++; $display("FAIL add2_flags_VCNZ got %b want 1101", {V, C, N, Z}); end
    read_reg(4'd5, v);
    checks++; if (v !== 16'h8000) begin errors++; $display("FAIL b2b_reg5 got %h want 8000", v); end
    read_reg(4'd6, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL b2b_reg6 got %h want 0000", v); end
  endtask

  task automatic test_load();
    logic [15:0] v;
    write_imm(4'd1, 16'h0010);
    RAM_data_out = 16'hDEAD;
    drive(1'b1, 1'b1, 1'b0, MB_ALU, FS_PASS_A, 4'd1, 4'd7, 4'd0, 6'd0, 16'd0);
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL load_stall_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL load_stall_out_valid got %b want 0", out_valid); end
    checks++; if (A_out !== 16'h0010) begin errors++; $display("FAIL load_addr got %h want 0010", A_out); end
    drive(1'b0, 1'b0, 1'b0, MB_ZERO, FS_PASS_A, 4'd0, 4'd0, 4'd0, 6'd0, 16'd0);
    tick();
    RAM_data_out = 16'hBEEF;
    checks++; if ({in_ready, out_valid} !== 2'b11) begin errors++; $display("FAIL load_retire_rdy_vld got %b want 11", {in_ready, out_valid}); end
    tick();
    in_valid = 1'b0;
    RAM_data_out = 16'hDEAD;
    checks++; if ({in_ready, out_valid} !== 2'b11) begin errors++; $display("FAIL after_load_rdy_vld got %b want 11", {in_ready, out_valid}); end
    tick();
    checks++; if ({V, C, N, Z} !== 4'b1101) begin errors++; $display("FAIL load_flags_hold got %b want 1101", {V, C, N, Z}); end
    read_reg(4'd7, v);
    checks++; if (v !== 16'hBEEF) begin errors++; $display("FAIL load_reg7 got %h want beef", v); end
  endtask

  task automatic test_pc_zero();
    logic [15:0] v;
    write_imm(4'd2, 16'hFFFF);
    drive(1'b1, 1'b0, 1'b0, MB_PC, FS_ADD, 4'd0, 4'd2, 4'd0, 6'h2A, 16'hFFFF);
    tick();
    in_valid = 1'b0;
    tick();
    read_reg(4'd2, v);
    checks++; if (v !== 16'h002A) begin errors++; $display("FAIL pc_reg2 got %h want 002a", v); end
    checks++; if ({V, C, N, Z} !== 4'b1101) begin errors++; $display("FAIL pc_flags_hold got %b want 1101", {V, C, N, Z}); end
    drive(1'b1, 1'b0, 1'b0, MB_ZERO, FS_SUB, 4'd1, 4'd2, 4'd0, 6'd0, 16'd0);
    tick();
    in_valid = 1'b0;
    tick();
    read_reg(4'd2, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL zero_reg2 got %h want 0000", v); end
    checks++; if ({V, C, N, Z} !== 4'b1101) begin errors++; $display("FAIL zero_flags_hold got %b want 1101", {V, C, N, Z}); end
  endtask

  task automatic test_reset_in_load();
    logic [15:0] v;
    drive(1'b1, 1'b1, 1'b0, MB_ALU, FS_PASS_A, 4'd1, 4'd8, 4'd3, 6'd0, 16'd0);
    tick();
    in_valid = 1'b0;
    tick();
    RAM_data_out = 16'h1111;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_abort_out_valid got %b want 1", out_valid); end
    reset = 1'b0;
    #1;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL abort_rdy_vld got %b want 10", {in_ready, out_valid}); end
    checks++; if ({A_out, B_out} !== 32'd0) begin errors++; $display("FAIL abort_operands got %h want 0", {A_out, B_out}); end
    checks++; if ({V, C, N, Z} !== 4'b0000) begin errors++; $display("FAIL abort_flags got %b want 0000", {V, C, N, Z}); end
    tick();
    tick();
    reset = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_release_in_ready got %b want 1", in_ready); end
    read_reg(4'd8, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL abort_reg8 got %h want 0000", v); end
  endtask

  task automatic test_width8();
    in_valid8 = 1'b1; RW8 = 1'b1; MD8 = 1'b0; MB8 = MB_IMM; FS8 = FS_PASS_A;
    SA8 = 3'd0; DR8 = 3'd1; BA8 = 3'd0; imdt8 = 8'h01;
    tick();
    in_valid8 = 1'b0;
    tick();
    in_valid8 = 1'b1; RW8 = 1'b1; MB8 = MB_ALU; FS8 = FS_SUB;
    SA8 = 3'd0; DR8 = 3'd2; BA8 = 3'd1; imdt8 = 8'h00;
    tick();
    checks++; if ({A_out8, B_out8} !== 16'h0001) begin errors++; $display("FAIL w8_operands got %h want 0001", {A_out8, B_out8}); end
    in_valid8 = 1'b0;
    tick();
    checks++; if ({V8, C8, N8, Z8} !== 4'b0110) begin errors++; $display("FAIL w8_sub_flags got %b want 0110", {V8, C8, N8, Z8}); end
    in_valid8 = 1'b1; RW8 = 1'b0; MB8 = MB_ZERO; FS8 = FS_PASS_A; SA8 = 3'd2;
    tick();
    checks++; if (A_out8 !== 8'hFF) begin errors++; $display("FAIL w8_reg2 got %h want ff", A_out8); end
    in_valid8 = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid = 1'b0; RW = 1'b0; MD = 1'b0; ASEL = 1'b0; MB = 2'd0; FS = 4'd0;
    SA = 4'd0; DR = 4'd0; BA = 4'd0; PC = 6'd0; imdt = 16'd0; RAM_data_out = 16'd0;
    in_valid8 = 1'b0; RW8 = 1'b0; MD8 = 1'b0; ASEL8 = 1'b0; MB8 = 2'd0; FS8 = 4'd0;
    SA8 = 3'd0; DR8 = 3'd0; BA8 = 3'd0; PC8 = 6'd0; imdt8 = 8'd0; RAM8 = 8'd0;
    tick();
    test_reset();
    test_imm_pass();
    test_back_to_back();
    test_load();
    test_pc_zero();
    test_reset_in_load();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_pipe.md
# datapath_pipe

Parametrised, two-stage pipelined successor to the single-cycle 16-bit datapath. It holds a REGS x WIDTH register file, an operand-select stage and an execute/writeback stage built around the ALU, with result forwarding and a registered V/C/N/Z flag set. Loads from the synchronous data RAM stall issue for one cycle through a valid/ready handshake. It sits between the control unit, which issues decoded control words, and the data RAM, which takes its address from A_out and its write data from B_out.

## Interface
- WIDTH, 16, datapath and register width (>= 8)
- REGS, 16, register count (power of 2); AW = clog2(REGS)
- PC_W, 6, program-counter width (<= WIDTH)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  1  control word below is valid
- in_ready  out  1  datapath accepts a control word this cycle
- RW  in  1  write result to register DR
- MD  in  1  0: ALU result, 1: RAM_data_out (load)
- ASEL  in  1  A-port address: 0 SA, 1 DR
- MB  in  2  writeback source: 0 MD-mux, 1 imdt, 2 zero-extended PC, 3 all-zero
- FS  in  4  ALU function; encodings from the package
- SA, DR, BA  in  AW each  source A, destination, source B register
- PC  in  PC_W  program counter, captured at issue
- imdt  in  WIDTH  immediate, captured at issue
- RAM_data_out  in  WIDTH  RAM read data, valid one cycle after A_out
- A_out, B_out  out  WIDTH  registered EX-stage operands (RAM address / write data)
- out_valid  out  1  pulses in the retire cycle of each instruction
- V, C, N, Z  out  1 each  registered flags of the last retired ALU instruction

## Operation
- Issue: a control word is accepted when in_valid && in_ready. At that edge, the A operand is read from reg[ASEL ? DR : SA] and the B operand from reg[BA]. Both operands, plus DR, RW, MD, MB, FS, imdt and PC, are captured into EX registers.
- Forwarding: if the retiring instruction writes register R (RW=1) at the same edge an issuing instruction reads R, the issuing instruction captures the write data, not the stale value. Applies independently to the A and B ports.
- Execute FSM, states EX_IDLE, EX_RUN, EX_LOAD:
  - EX_IDLE: nothing in EX. On accept, go to EX_RUN.
  - EX_RUN with MD=0: retire this cycle (write if RW, out_valid=1). Go to EX_RUN on a new accept, otherwise EX_IDLE.
  - EX_RUN with MD=1: A_out is the RAM address, in_ready=0, go to EX_LOAD.
  - EX_LOAD: retire using RAM_data_out, in_ready=1, next state as for EX_RUN with MD=0.
- Writeback value: MB=0 gives MD ? RAM_data_out : ALU F. MB=1 gives imdt. MB=2 gives {0, PC}. MB=3 gives 0.
- Flags: V/C/N/Z update only when an instruction retires with MD=0 and MB=0; otherwise they hold. All arithmetic is at WIDTH bits. C is the carry/borrow out of bit WIDTH-1. V is signed overflow. N is F[WIDTH-1]. Z is (F==0).
- Register 0 is general purpose (not hardwired).
- Simultaneous events: a write and a read of the same register in one cycle resolve by forwarding. Two writes are impossible because there is a single writeback port.

## Timing
- Reset values: all registers 0, FSM EX_IDLE, A_out=B_out=0, V=C=N=Z=0, out_valid=0, in_ready=1.
- Reset asserted mid-operation aborts the in-flight instruction with no register write and no flag update. in_ready is 1 on the first cycle after release.
- Latency from accept to retire is 1 cycle for ALU/immediate/PC instructions and 2 cycles for loads.
- Throughput is 1 instruction/cycle, except that each load inserts one in_ready=0 cycle.
- in_ready is combinational from FSM state only, with no dependence on in_valid.
- out_valid is combinational, high during the retire cycle. The register write and flag update occur at the closing edge of that cycle.

## Structure
- Package datapath_pkg holds the FS encodings (FS_PASS_A, FS_INC, FS_ADD, FS_SUB, FS_AND, FS_OR, FS_XOR, FS_NOT, FS_SHL, FS_SHR), the MB_* select constants and the ex_state_t enum.
- Sub-module alu_param (parameter WIDTH) is purely combinational: A, B, FS in; F, V, C, N, Z out.
- The register file, forwarding logic and FSM stay in datapath_pipe.

## Test plan
- Reset then issue MB=1, imdt=0x1234, DR=3, RW=1; then SA=3, FS=FS_PASS_A, MB=0, DR=4 -> out_valid on both cycles, reg4=0x1234, Z=0, N=0.
- Back-to-back: reg1=0x7FFF and reg2=0x0001, then ADD DR=5 immediately followed by ADD SA=5, BA=5, DR=6 -> forwarding gives reg5=0x8000 with V=1, N=1, then reg6=0x0000 with C=1, Z=1, V=1.
- Load: MD=1, SA=1 (reg1=0x0010), RAM returns 0xBEEF one cycle after A_out=0x0010 -> in_ready low for exactly one cycle, reg7=0xBEEF, flags unchanged.
- MB=2 with PC=6'h2A, DR=2 -> reg2=0x002A. MB=3, DR=2 -> reg2=0x0000, flags unchanged.
- Reset asserted during EX_LOAD -> no write to DR, FSM EX_IDLE, all outputs at reset values.
- WIDTH=8, REGS=8 build: SUB 0x00-0x01 -> F=0xFF, C=1, N=1, Z=0.
